// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state width, byte indexing helper,
// state type and the default width of the round tag.
package aes_pkg;

    localparam int STATE_W       = 128;
    localparam int DEFAULT_TAG_W = 4;

    typedef logic [STATE_W-1:0] aes_state_t;

    // Column-major byte index: byte b lives at bits [127-8b -: 8].
    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

endpackage

// File: rtl/inv_shift_row_comb.sv
// Purely combinational InvShiftRows byte permutation:
//   out(r,c) = in(r, (c - r) mod 4)
// Row r rotates right by r byte positions; row 0 passes straight through.
module inv_shift_row_comb
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] result
);

    // Pure wiring: each output byte selects one input byte of the same row.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int DST = byte_idx(r, c);
            localparam int SRC = byte_idx(r, (c - r + 4) % 4);
            assign result[STATE_W-1-8*DST -: 8] = state[STATE_W-1-8*SRC -: 8];
        end
    end

endmodule

// File: rtl/inv_shift_row_stage.sv
// Registered InvShiftRows stage for the iterative AES decrypt round.
// The permuted state and its round tag are held in a 2-entry skid buffer;
// in_ready depends only on the registered occupancy, never on out_ready.
// Optional build macro INV_SHIFT_ROW_ADDKEY_EN adds port in_key and stores
// InvShiftRows(in_state) ^ in_key instead of the plain permutation.
module inv_shift_row_stage
    import aes_pkg::*;
#(
    parameter int TAG_W = DEFAULT_TAG_W,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [STATE_W-1:0]  in_state,
    input  logic [TAG_W-1:0]    in_tag,
`ifdef INV_SHIFT_ROW_ADDKEY_EN
    input  logic [STATE_W-1:0]  in_key,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [STATE_W-1:0]  out_state,
    output logic [TAG_W-1:0]    out_tag
);

    if (DEPTH != 2) begin : g_depth_check
        $error("inv_shift_row_stage: only DEPTH = 2 is supported");
    end

    logic [STATE_W-1:0] shifted;
    logic [STATE_W-1:0] stored_state;

    aes_state_t         state_mem [2];
    logic [TAG_W-1:0]   tag_mem   [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;

    logic               push;
    logic               pop;

    inv_shift_row_comb u_perm (
        .state  (in_state),
        .result (shifted)
    );

`ifdef INV_SHIFT_ROW_ADDKEY_EN
    assign stored_state = shifted ^ in_key;
`else
    assign stored_state = shifted;
`endif

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer storage, pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the entries are cleared on reset as well as the control
            // state, so nothing from before reset can ever reach out_state.
            state_mem[0] <= '0;
            state_mem[1] <= '0;
            tag_mem[0]   <= '0;
            tag_mem[1]   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values, whatever the statement order.
            if (push) begin
                state_mem[wr_ptr] <= stored_state;
                tag_mem[wr_ptr]   <= in_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head entry drives the outputs; they read as zero while empty.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        out_state = '0;
        out_tag   = '0;
        if (out_valid) begin
            out_state = state_mem[rd_ptr];
            out_tag   = tag_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inv_shift_row_stage.sv
// Self-checking bench for inv_shift_row_stage. A queue-based model holds
// the expected buffer contents; the permutation is modelled as per-row
// rotations of a 4x4 byte matrix. Define INV_SHIFT_ROW_ADDKEY_EN to also
// exercise the fused key XOR.
module tb_inv_shift_row_stage;

    localparam int TAG_W = 4;
    localparam int BUS_W = 130 + TAG_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_state;
    logic [TAG_W-1:0]   in_tag;
`ifdef INV_SHIFT_ROW_ADDKEY_EN
    logic [127:0]       in_key;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_state;
    logic [TAG_W-1:0]   out_tag;

    int vectors = 0;
    int fails   = 0;

    typedef struct packed {
        logic [127:0]     st;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t exp_q[$];

    always #5 clk = ~clk;

    inv_shift_row_stage #(.TAG_W(TAG_W), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_tag    (in_tag),
`ifdef INV_SHIFT_ROW_ADDKEY_EN
        .in_key    (in_key),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag)
    );

    // Row r of the state matrix rotated right by r positions.
    function automatic logic [127:0] model_inv_shift(input logic [127:0] s);
        logic [7:0] m [4][4];
        logic [7:0] o [4][4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][(c+r)%4] = m[r][c];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = o[r][c];
        return res;
    endfunction

    function automatic logic [127:0] model_store(input logic [127:0] s, input logic [127:0] k);
`ifdef INV_SHIFT_ROW_ADDKEY_EN
        return model_inv_shift(s) ^ k;
`else
        return model_inv_shift(s) | (k & 128'h0);
`endif
    endfunction

    // Expected {out_valid, in_ready, out_state, out_tag} from the model queue.
    function automatic logic [BUS_W-1:0] exp_bus();
        if (exp_q.size() == 0)
            return {1'b0, 1'b1, 128'h0, {TAG_W{1'b0}}};
        return {1'b1, exp_q.size() != 2, exp_q[0].st, exp_q[0].tag};
    endfunction

    function automatic logic [BUS_W-1:0] obs_bus();
        return {out_valid, in_ready, out_state, out_tag};
    endfunction

    // Drive one cycle at the current negedge, advance the model across the
    // following posedge, and return at the next negedge.
    task automatic step(input logic v, input logic [127:0] s, input logic [TAG_W-1:0] t,
                        input logic [127:0] k, input logic r, input logic f);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_state  = s;
        in_tag    = t;
`ifdef INV_SHIFT_ROW_ADDKEY_EN
        in_key    = k;
`endif
        out_ready = r;
        flush     = f;
        do_push   = v && (exp_q.size() < 2);
        do_pop    = r && (exp_q.size() > 0);
        @(posedge clk);
        if (f) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{st: model_store(s, k), tag: t});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++)
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain out_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_state = '0; in_tag = '0;
        out_ready = 1'b0;
`ifdef INV_SHIFT_ROW_ADDKEY_EN
        in_key = '0;
`endif
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        vectors++;
        if (obs_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL reset_held got %h want %h", obs_bus(), exp_bus());
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_bus() !== {1'b0, 1'b1, 128'h0, {TAG_W{1'b0}}}) begin
            fails++;
            $display("FAIL reset_release got %h want idle", obs_bus());
        end
    endtask

    task automatic test_mapping();
        step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 4'd3, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_state !== 128'h000d0a0704010e0b0805020f0c090603
            || out_tag !== 4'd3) begin
            fails++;
            $display("FAIL mapping got v=%0b %h tag=%0d want v=1 000d0a0704010e0b0805020f0c090603 tag=3",
                     out_valid, out_state, out_tag);
        end
        step(1'b1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 4'd1, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_state !== 128'h7a9f102789d5f50b2beffd9f3dca4ea7
            || out_tag !== 4'd1) begin
            fails++;
            $display("FAIL fips_c1 got v=%0b %h tag=%0d want v=1 7a9f102789d5f50b2beffd9f3dca4ea7 tag=1",
                     out_valid, out_state, out_tag);
        end
        drain();
    endtask

`ifdef INV_SHIFT_ROW_ADDKEY_EN
    task automatic test_addkey();
        step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 4'd5, {128{1'b1}}, 1'b1, 1'b0);
        vectors++;
        if (out_state !== 128'hfff2f5f8fbfef1f4f7fafdf0f3f6f9fc || out_tag !== 4'd5) begin
            fails++;
            $display("FAIL addkey got %h tag=%0d want fff2f5f8fbfef1f4f7fafdf0f3f6f9fc tag=5",
                     out_state, out_tag);
        end
        drain();
    endtask
`endif

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] b;
        a = {4{$urandom()}};
        b = {4{$urandom()}};
        step(1'b1, a, 4'd10, '0, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1 || out_state !== model_inv_shift(a)) begin
            fails++;
            $display("FAIL bp_first got rdy=%0b %h want rdy=1 %h", in_ready, out_state, model_inv_shift(a));
        end
        step(1'b1, b, 4'd11, '0, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || out_state !== model_inv_shift(a) || out_tag !== 4'd10) begin
            fails++;
            $display("FAIL bp_full got rdy=%0b %h tag=%0d want rdy=0 %h tag=10",
                     in_ready, out_state, out_tag, model_inv_shift(a));
        end
        // Extra offer while full must be ignored; head stays A.
        step(1'b1, ~a, 4'd12, '0, 1'b0, 1'b0);
        vectors++;
        if (obs_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL bp_hold got %h want %h", obs_bus(), exp_bus());
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (in_ready !== 1'b1 || out_state !== model_inv_shift(b) || out_tag !== 4'd11) begin
            fails++;
            $display("FAIL bp_second got rdy=%0b %h tag=%0d want rdy=1 %h tag=11",
                     in_ready, out_state, out_tag, model_inv_shift(b));
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (obs_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL bp_empty got %h want %h", obs_bus(), exp_bus());
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, {4{$urandom()}}, TAG_W'(i), {4{$urandom()}}, 1'b1, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || out_tag !== TAG_W'(i) || obs_bus() !== exp_bus()) begin
                fails++;
                $display("FAIL stream[%0d] got %h want %h", i, obs_bus(), exp_bus());
            end
        end
        drain();
    endtask

    task automatic test_flush();
        step(1'b1, {4{$urandom()}}, 4'd7, '0, 1'b0, 1'b0);
        step(1'b1, {4{$urandom()}}, 4'd8, '0, 1'b0, 1'b0);
        step(1'b1, {4{$urandom()}}, 4'd9, '0, 1'b1, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0 || out_tag !== '0) begin
            fails++;
            $display("FAIL flush got v=%0b rdy=%0b %h tag=%0d want v=0 rdy=1 0 tag=0",
                     out_valid, in_ready, out_state, out_tag);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, {4{$urandom()}}, 4'd2, '0, 1'b0, 1'b0);
        step(1'b1, {4{$urandom()}}, 4'd4, '0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0 || out_tag !== '0) begin
            fails++;
            $display("FAIL async_rst got v=%0b rdy=%0b %h tag=%0d want v=0 rdy=1 0 tag=0",
                     out_valid, in_ready, out_state, out_tag);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic             pend_v = 1'b0;
        logic [127:0]     pend_s = '0;
        logic [127:0]     pend_k = '0;
        logic [TAG_W-1:0] pend_t = '0;
        logic             rdy;
        logic             fl;
        logic             acc;
        for (int i = 0; i < 300; i++) begin
            if (!pend_v || acc) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend_s = {4{$urandom()}};
                pend_k = {4{$urandom()}};
                pend_t = TAG_W'($urandom());
            end
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            acc = pend_v && (exp_q.size() < 2);
            step(pend_v, pend_s, pend_t, pend_k, rdy, fl);
            vectors++;
            if (obs_bus() !== exp_bus()) begin
                fails++;
                $display("FAIL random[%0d] got %h want %h", i, obs_bus(), exp_bus());
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_mapping();
`ifdef INV_SHIFT_ROW_ADDKEY_EN
        test_addkey();
`endif
        test_backpressure();
        test_streaming();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
